// File: rtl/lut_pkg.sv
// Shared LUT constants and the loader state encoding.
// Also used by the downstream interpolator.
package lut_pkg;
  localparam int LUT_DW       = 8;
  localparam int LUT_XW       = 8;
  localparam int LUT_P        = 6;
  localparam int LUT_DEPTH    = 64;
  localparam int LUT_DEPTH_IN = 256;
  localparam int LUT_DECIM    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } lutState_t;
endpackage

// File: rtl/lut_table_loader_if.sv
// Table-load stream, dual read ports and status flags between loader and its users.
// The slave modport is the loader side.
interface lut_table_loader_if;
  import lut_pkg::*;

  logic              load_start;
  logic              in_valid;
  logic [LUT_DW-1:0] in_data;
  logic              in_ready;
  logic [LUT_P-1:0]  rd_addr_a;
  logic [LUT_P-1:0]  rd_addr_b;
  logic [LUT_DW-1:0] rd_data_a;
  logic [LUT_DW-1:0] rd_data_b;
  logic              table_valid;
  logic              load_done;
  logic              err;

  modport slave (
    input  load_start, in_valid, in_data, rd_addr_a, rd_addr_b,
    output in_ready, rd_data_a, rd_data_b, table_valid, load_done, err
  );

  modport master (
    output load_start, in_valid, in_data, rd_addr_a, rd_addr_b,
    input  in_ready, rd_data_a, rd_data_b, table_valid, load_done, err
  );
endinterface

// File: rtl/lut_regfile.sv
// LUT storage: one synchronous write port, two combinational read ports.
// Latency: write visible on reads the cycle after wrEn; no backpressure, reads always served.
module lut_regfile #(
  parameter int DW    = 8,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wrEn,
  input  logic [AW-1:0] wrAddr,
  input  logic [DW-1:0] wrData,
  input  logic [AW-1:0] rdAddrA,
  output logic [DW-1:0] rdDataA,
  input  logic [AW-1:0] rdAddrB,
  output logic [DW-1:0] rdDataB
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign rdDataA = mem[rdAddrA];
  assign rdDataB = mem[rdAddrB];

endmodule

// File: rtl/lut_table_loader.sv
// Streams a full-resolution table in, keeps every DECIM-th byte; optional LUT_LOADER_CHECKSUM_EN.
// Latency: stored byte readable 1 cycle after acceptance; load_done 1 cycle after last byte.
// Backpressure: in_ready high only in LOAD/CHECK; read ports never stall.
module lut_table_loader
  import lut_pkg::*;
#(
  parameter int DW       = LUT_DW,
  parameter int DEPTH_IN = LUT_DEPTH_IN,
  parameter int DECIM    = LUT_DECIM
) (
  input logic               clk,
  input logic               rst,
  lut_table_loader_if.slave bus
);

  localparam int CntW  = $clog2(DEPTH_IN);
  localparam int SkipW = $clog2(DECIM);
  localparam int Depth = DEPTH_IN / DECIM;

  lutState_t           state;
  lutState_t           nextState;
  logic [CntW-1:0]     count;
  logic                tableValid;
  logic                inReady;
  logic                accept;
  logic                lastByte;
  logic                wrEn;
  logic                loadDone;
  logic                ckFail;

  assign inReady  = (state == LOAD) || (state == CHECK);
  assign accept   = bus.in_valid && inReady;
  assign lastByte = (count == CntW'(DEPTH_IN - 1));

`ifdef LUT_LOADER_CHECKSUM_EN
  logic [DW-1:0] sum;
  logic          errReg;
  logic          sumOk;

  assign sumOk = (bus.in_data == sum);
`endif

  always_comb begin
    nextState = state;
    wrEn      = 1'b0;
    loadDone  = 1'b0;
    ckFail    = 1'b0;
    case (state)
      IDLE: ;
      LOAD: begin
        if (accept) begin
          wrEn = (count[SkipW-1:0] == '0);
          if (lastByte) begin
`ifdef LUT_LOADER_CHECKSUM_EN
            nextState = CHECK;
`else
            nextState = DONE;
`endif
          end
        end
      end
      CHECK: begin
`ifdef LUT_LOADER_CHECKSUM_EN
        if (accept) begin
          nextState = sumOk ? DONE : IDLE;
          ckFail    = !sumOk;
        end
`else
        nextState = IDLE;
`endif
      end
      DONE: begin
        loadDone  = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
    // A (re)start wins over any byte handshaking in the same cycle; that byte is dropped.
    if (bus.load_start) begin
      nextState = LOAD;
      wrEn      = 1'b0;
      ckFail    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      tableValid <= 1'b0;
    end else begin
      state <= nextState;
      if (bus.load_start) begin
        count      <= '0;
        tableValid <= 1'b0;
      end else begin
        if (state == LOAD && accept) begin
          count <= count + 1'b1;
        end
        if (state == DONE) begin
          tableValid <= 1'b1;
        end
      end
    end
  end

`ifdef LUT_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum    <= '0;
      errReg <= 1'b0;
    end else if (bus.load_start) begin
      sum    <= '0;
      errReg <= 1'b0;
    end else begin
      if (state == LOAD && accept) begin
        sum <= sum + bus.in_data;
      end
      if (ckFail) begin
        errReg <= 1'b1;
      end
    end
  end

  assign bus.err = errReg;
`else
  assign bus.err = ckFail;
`endif

  lut_regfile #(
    .DW    (DW),
    .DEPTH (Depth),
    .AW    (CntW - SkipW)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .wrEn    (wrEn),
    .wrAddr  (count[CntW-1:SkipW]),
    .wrData  (bus.in_data),
    .rdAddrA (bus.rd_addr_a),
    .rdDataA (bus.rd_data_a),
    .rdAddrB (bus.rd_addr_b),
    .rdDataB (bus.rd_data_b)
  );

  assign bus.in_ready    = inReady;
  assign bus.table_valid = tableValid;
  assign bus.load_done   = loadDone;

endmodule
